// File: rtl/encrypt_round_pipe_if.sv
// Stream and configuration bundle for encrypt_round_pipe.
// The master side is the source/sink/config host; the slave side is the cipher.
interface encrypt_round_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_mode;
    logic              cfg_we;
    logic              cfg_sel;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_commit;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        output cfg_we, cfg_sel, cfg_addr, cfg_wdata, cfg_commit,
        input  in_ready, out_valid, out_data, out_mode,
        input  cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, cfg_commit,
        output in_ready, out_valid, out_data, out_mode,
        output cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/encrypt_round_pipe.sv
// Multi-round XOR/permute cipher pipeline, one round per stage, with
// shadow key/permutation tables committed through a drain/check/apply FSM.
module encrypt_round_pipe #(
    parameter int DATA_W     = 8,
    parameter int NUM_ROUNDS = 3
) (
    input logic                 clk,
    input logic                 rst,
    encrypt_round_pipe_if.slave bus
);
    localparam int PW     = $clog2(DATA_W);
    localparam int RW     = $clog2(NUM_ROUNDS);
    localparam int AW0    = (PW > RW) ? PW : RW;
    localparam int ADDR_W = (AW0 > 1) ? AW0 : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CHECK, S_APPLY} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_key_act [NUM_ROUNDS];
    logic [DATA_W-1:0] r_key_sh  [NUM_ROUNDS];
    logic [PW-1:0]     r_perm_act [DATA_W];
    logic [PW-1:0]     r_perm_sh  [DATA_W];
    logic [DATA_W-1:0] r_seen;
    logic              r_bad;
    logic [PW-1:0]     r_j;
    logic              r_busy;
    logic              r_done;
    logic              r_cerr;

    logic [NUM_ROUNDS-1:0] r_vld;
    logic [DATA_W-1:0]     r_dat  [NUM_ROUNDS];
    logic [NUM_ROUNDS-1:0] r_mode;

    logic [NUM_ROUNDS:0]   w_ce;
    logic [NUM_ROUNDS-1:0] w_vin;
    logic [NUM_ROUNDS-1:0] w_min;
    logic [DATA_W-1:0]     w_nxt [NUM_ROUNDS];
    logic                  w_in_ready;
    logic                  w_acc;

    function automatic logic [DATA_W-1:0] key_def(input int r);
        logic [7:0] b;
        case (r % 3)
            0:       b = 8'hDE;
            1:       b = 8'hAD;
            default: b = 8'hBE;
        endcase
        return {(DATA_W/8){b}};
    endfunction

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        w_ce[NUM_ROUNDS] = bus.out_ready;
        for (int s = NUM_ROUNDS - 1; s >= 0; s--) begin
            w_ce[s] = !r_vld[s] | w_ce[s+1];
        end
    end

    assign w_in_ready = (r_state == S_IDLE) & w_ce[0] & !rst;
    assign w_acc      = bus.in_valid & w_in_ready;

    for (genvar s = 0; s < NUM_ROUNDS; s++) begin : g_rnd
        logic [DATA_W-1:0] w_x;
        logic [DATA_W-1:0] w_k;
        logic [DATA_W-1:0] w_t;
        logic [DATA_W-1:0] w_y;
        logic [DATA_W-1:0] w_z;
        logic              w_m;

        if (s == 0) begin : g_head
            assign w_x      = bus.in_data;
            assign w_m      = bus.in_mode;
            assign w_vin[s] = w_acc;
        end else begin : g_body
            assign w_x      = r_dat[s-1];
            assign w_m      = r_mode[s-1];
            assign w_vin[s] = r_vld[s-1];
        end

        // Decrypt walks the key schedule backwards.
        assign w_k = w_m ? r_key_act[NUM_ROUNDS-1-s] : r_key_act[s];
        assign w_t = w_x ^ w_k;

        always_comb begin
            w_y = '0;
            w_z = '0;
            for (int i = 0; i < DATA_W; i++) begin
                w_y[i]             = w_t[r_perm_act[i]];
                w_z[r_perm_act[i]] = w_x[i];
            end
        end

        assign w_nxt[s] = w_m ? (w_z ^ w_k) : w_y;
        assign w_min[s] = w_m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_mode <= '0;
            for (int s = 0; s < NUM_ROUNDS; s++) begin
                r_dat[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_ROUNDS; s++) begin
                if (w_ce[s]) begin
                    r_vld[s] <= w_vin[s];
                    if (w_vin[s]) begin
                        r_dat[s]  <= w_nxt[s];
                        r_mode[s] <= w_min[s];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cerr  <= 1'b0;
            r_seen  <= '0;
            r_bad   <= 1'b0;
            r_j     <= '0;
            for (int r = 0; r < NUM_ROUNDS; r++) begin
                r_key_act[r] <= key_def(r);
                r_key_sh[r]  <= key_def(r);
            end
            for (int i = 0; i < DATA_W; i++) begin
                r_perm_act[i] <= PW'(DATA_W - 1 - i);
                r_perm_sh[i]  <= PW'(DATA_W - 1 - i);
            end
        end else begin
            r_done <= 1'b0;
            r_cerr <= 1'b0;
            if (bus.cfg_we && r_state != S_CHECK && r_state != S_APPLY) begin
                for (int r = 0; r < NUM_ROUNDS; r++) begin
                    if (!bus.cfg_sel && bus.cfg_addr == ADDR_W'(r)) begin
                        r_key_sh[r] <= bus.cfg_wdata;
                    end
                end
                for (int i = 0; i < DATA_W; i++) begin
                    if (bus.cfg_sel && bus.cfg_addr == ADDR_W'(i)) begin
                        r_perm_sh[i] <= bus.cfg_wdata[PW-1:0];
                    end
                end
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cfg_commit) begin
                        r_state <= S_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_vld == '0) begin
                        r_state <= S_CHECK;
                        r_seen  <= '0;
                        r_bad   <= 1'b0;
                        r_j     <= '0;
                    end
                end
                S_CHECK: begin
                    // Bijection test: every source index must appear once.
                    r_seen[r_perm_sh[r_j]] <= 1'b1;
                    if (r_seen[r_perm_sh[r_j]] ||
                        int'(r_perm_sh[r_j]) >= DATA_W) begin
                        r_bad <= 1'b1;
                    end
                    if (r_j == PW'(DATA_W - 1)) begin
                        r_state <= S_APPLY;
                    end else begin
                        r_j <= r_j + PW'(1);
                    end
                end
                S_APPLY: begin
                    if (!r_bad) begin
                        r_key_act  <= r_key_sh;
                        r_perm_act <= r_perm_sh;
                        r_done     <= 1'b1;
                    end else begin
                        r_cerr <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld[NUM_ROUNDS-1];
    assign bus.out_data  = r_dat[NUM_ROUNDS-1];
    assign bus.out_mode  = r_mode[NUM_ROUNDS-1];
    assign bus.cfg_busy  = r_busy;
    assign bus.cfg_done  = r_done;
    assign bus.cfg_err   = r_cerr;
endmodule
